// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase scheduler: state codes,
// signal-head encodings and the green-exit decision.
package traffic_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_G1   = 3'd0;
    localparam state_t ST_Y1   = 3'd1;
    localparam state_t ST_AR1  = 3'd2;
    localparam state_t ST_G2   = 3'd3;
    localparam state_t ST_Y2   = 3'd4;
    localparam state_t ST_AR2  = 3'd5;
    localparam state_t ST_WALK = 3'd6;

    // Signal head: [2]=green, [1]=yellow, [0]=red.
    localparam logic [2:0] LT_GREEN  = 3'b100;
    localparam logic [2:0] LT_YELLOW = 3'b010;
    localparam logic [2:0] LT_RED    = 3'b001;

    // Seconds-in-state counter saturates here while a green rests.
    localparam logic [7:0] SEC_MAX = 8'hFF;

    // A green ends only if someone else is waiting, and then either at the
    // maximum or, once the minimum is served, as soon as its own demand goes.
    function automatic logic green_exit(
        input logic [8:0] elapsed,
        input logic [8:0] green_min,
        input logic [8:0] green_max,
        input logic       own_demand,
        input logic       conflict
    );
        return conflict &&
               ((elapsed >= green_max) || ((elapsed >= green_min) && !own_demand));
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_tick_gen.sv
// One-second tick prescaler. Restarts from zero on clr so every state
// begins with a full tick period.
module tick_gen #(
    parameter int TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int                CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Count 0..TICK_DIV-1, wrapping on the last count or on a state change.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments in clocked blocks so every register
        // samples pre-edge values regardless of block ordering.
        if (rst)
            r_cnt <= '0;
        else if (clr || (r_cnt == CNT_LAST))
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Actuated two-approach intersection controller with a pedestrian walk
// phase. Phase FSM, seconds timer, pedestrian latch and Moore light decode.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int TICK_DIV  = 100000000,
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 15,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sense1,
    input  logic       sense2,
    input  logic       ped_req,
    output logic       ped_ack,
    output logic       walk,
    output logic [2:0] light1,
    output logic [2:0] light2,
    output logic [2:0] phase
);

    localparam logic [8:0] P_GMIN = 9'(GREEN_MIN);
    localparam logic [8:0] P_GMAX = 9'(GREEN_MAX);
    localparam logic [8:0] P_YEL  = 9'(YELLOW_T);
    localparam logic [8:0] P_AR   = 9'(ALLRED_T);
    localparam logic [8:0] P_WALK = 9'(WALK_T);

    state_t     r_state;
    state_t     w_state_next;
    state_t     r_next_after_walk;
    logic       w_tick;
    logic       w_state_change;
    logic [7:0] r_sec;
    logic [8:0] w_elapsed;
    logic       r_ped_pending;
    logic       r_ped_ack;
    logic       w_ped_accept;
    logic       w_walk_entry;

    assign w_state_change = (w_state_next != r_state);
    assign w_elapsed      = {1'b0, r_sec} + 9'd1;
    assign w_walk_entry   = (w_state_next == ST_WALK) && (r_state != ST_WALK);
    assign w_ped_accept   = ped_req && !r_ped_pending && (r_state != ST_WALK);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_state_change),
        .tick (w_tick)
    );

    // State register; reset parks in AR2 so the first green served is G1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_AR2;
        else
            r_state <= w_state_next;
    end

    // Next-state logic: greens are actuated, the other states are timed.
    always_comb begin
        // NOTE: default assignment first so no path through the case can
        // leave the signal unassigned and infer a latch.
        w_state_next = r_state;
        case (r_state)
            ST_G1:
                if (w_tick && green_exit(w_elapsed, P_GMIN, P_GMAX, sense1,
                                         sense2 | r_ped_pending))
                    w_state_next = ST_Y1;
            ST_Y1:
                if (w_tick && (w_elapsed == P_YEL))
                    w_state_next = ST_AR1;
            ST_AR1:
                if (w_tick && (w_elapsed == P_AR))
                    w_state_next = r_ped_pending ? ST_WALK : ST_G2;
            ST_G2:
                if (w_tick && green_exit(w_elapsed, P_GMIN, P_GMAX, sense2,
                                         sense1 | r_ped_pending))
                    w_state_next = ST_Y2;
            ST_Y2:
                if (w_tick && (w_elapsed == P_YEL))
                    w_state_next = ST_AR2;
            ST_AR2:
                if (w_tick && (w_elapsed == P_AR))
                    w_state_next = r_ped_pending ? ST_WALK : ST_G1;
            ST_WALK:
                if (w_tick && (w_elapsed == P_WALK))
                    w_state_next = r_next_after_walk;
            default:
                w_state_next = ST_AR2;
        endcase
    end

    // Moore output decode from the state register only.
    always_comb begin
        light1 = LT_RED;
        light2 = LT_RED;
        walk   = 1'b0;
        case (r_state)
            ST_G1:   light1 = LT_GREEN;
            ST_Y1:   light1 = LT_YELLOW;
            ST_G2:   light2 = LT_GREEN;
            ST_Y2:   light2 = LT_YELLOW;
            ST_WALK: walk   = 1'b1;
            default: ;
        endcase
    end

    assign phase   = r_state;
    assign ped_ack = r_ped_ack;

    // Seconds spent in the current state; restarts on every transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_sec <= '0;
        else if (w_state_change)
            r_sec <= '0;
        else if (w_tick && (r_sec != SEC_MAX))
            r_sec <= r_sec + 8'd1;
    end

    // Pedestrian latch, acknowledge pulse and the green that follows WALK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ped_pending     <= 1'b0;
            r_ped_ack         <= 1'b0;
            r_next_after_walk <= ST_G1;
        end else begin
            r_ped_ack <= w_ped_accept;
            if (w_walk_entry)
                r_ped_pending <= 1'b0;
            else if (w_ped_accept)
                r_ped_pending <= 1'b1;
            if (w_walk_entry)
                r_next_after_walk <= (r_state == ST_AR1) ? ST_G2 : ST_G1;
        end
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler: the stimulus pushes the
// expected phase sequence (with per-phase durations in cycles) and the
// expected acknowledge pulses; a negedge monitor pops and compares.
module tb_traffic_phase_scheduler;

    logic       clk;
    logic       rst;
    logic       sense1;
    logic       sense2;
    logic       ped_req;
    logic       ped_ack;
    logic       walk;
    logic [2:0] light1;
    logic [2:0] light2;
    logic [2:0] phase;

    typedef struct {
        logic [2:0] ph;
        logic [2:0] l1;
        logic [2:0] l2;
        logic       wk;
        int         dur;   // expected cycles in this phase, 0 = not checked
    } exp_t;

    exp_t phase_q[$];
    int   ack_q[$];

    int n_checks = 0;
    int n_errors = 0;

    traffic_phase_scheduler #(
        .TICK_DIV  (4),
        .GREEN_MIN (2),
        .GREEN_MAX (4),
        .YELLOW_T  (1),
        .ALLRED_T  (1),
        .WALK_T    (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sense1  (sense1),
        .sense2  (sense2),
        .ped_req (ped_req),
        .ped_ack (ped_ack),
        .walk    (walk),
        .light1  (light1),
        .light2  (light2),
        .phase   (phase)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected heads for each phase code, from the light table.
    task automatic push_phase(input logic [2:0] ph, input int dur);
        exp_t e;
        e.ph  = ph;
        e.dur = dur;
        e.l1  = 3'b001;
        e.l2  = 3'b001;
        e.wk  = 1'b0;
        case (ph)
            3'd0: e.l1 = 3'b100;
            3'd1: e.l1 = 3'b010;
            3'd3: e.l2 = 3'b100;
            3'd4: e.l2 = 3'b010;
            3'd6: e.wk = 1'b1;
            default: ;
        endcase
        phase_q.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Assert reset (entering AR2 at once), set sensors, release after 3 edges.
    task automatic do_reset(input logic s1, input logic s2);
        push_phase(3'd5, 4);
        rst     = 1'b1;
        sense1  = s1;
        sense2  = s2;
        ped_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compare on every phase change, every cycle's heads, and acks.
    exp_t       cur;
    logic       have_cur   = 1'b0;
    logic [3:0] prev_phase = 4'hF;
    int         run_len    = 0;

    always @(negedge clk) begin
        if ({1'b0, phase} != prev_phase) begin
            if (have_cur && cur.dur != 0)
                check("duration", run_len, cur.dur);
            if (phase_q.size() == 0) begin
                check("phase_unexpected", int'(phase), int'(prev_phase));
            end else begin
                cur      = phase_q.pop_front();
                have_cur = 1'b1;
                check("phase", int'(phase), int'(cur.ph));
            end
            prev_phase = {1'b0, phase};
            run_len    = 0;
        end
        if (have_cur)
            check("heads", int'({light1, light2, walk}), int'({cur.l1, cur.l2, cur.wk}));
        check("one_head_only", int'((light1 != 3'b001) && (light2 != 3'b001)), 0);
        if (ped_ack) begin
            if (ack_q.size() == 0)
                check("ack_spurious", int'(ped_ack), 0);
            else
                check("ack_phase", int'(phase), ack_q.pop_front());
        end
        if (rst)
            run_len = 0;
        else
            run_len++;
    end

    initial begin
        sense1  = 1'b0;
        sense2  = 1'b0;
        ped_req = 1'b0;

        // 1: idle start, AR2 for 4 cycles, then G1 rests with no demand.
        do_reset(1'b0, 1'b0);
        push_phase(3'd0, 0);
        wait_cycles(124);

        // 2: both approaches demand: greens run to GREEN_MAX (16 cycles).
        do_reset(1'b1, 1'b1);
        push_phase(3'd0, 16);
        push_phase(3'd1, 4);
        push_phase(3'd2, 4);
        push_phase(3'd3, 16);
        push_phase(3'd4, 4);
        push_phase(3'd5, 4);
        push_phase(3'd0, 0);
        wait_cycles(60);

        // 3: only approach 2 demands: G1 ends at GREEN_MIN, G2 then rests.
        do_reset(1'b0, 1'b1);
        push_phase(3'd0, 8);
        push_phase(3'd1, 4);
        push_phase(3'd2, 4);
        push_phase(3'd3, 0);
        wait_cycles(40);

        // 4: single ped pulse in G1, second pulse while pending is ignored.
        do_reset(1'b0, 1'b0);
        push_phase(3'd0, 20);
        push_phase(3'd1, 4);
        push_phase(3'd2, 4);
        push_phase(3'd6, 8);
        push_phase(3'd3, 0);
        ack_q.push_back(0);
        wait_cycles(20);
        ped_req = 1'b1;
        wait_cycles(1);
        ped_req = 1'b0;
        wait_cycles(4);
        ped_req = 1'b1;
        wait_cycles(1);
        ped_req = 1'b0;
        wait_cycles(34);

        // 5: ped_req held through WALK: no ack inside WALK, re-ack in G2,
        //    and the following all-red leads to WALK again.
        do_reset(1'b0, 1'b0);
        push_phase(3'd0, 20);
        push_phase(3'd1, 4);
        push_phase(3'd2, 4);
        push_phase(3'd6, 8);
        push_phase(3'd3, 8);
        push_phase(3'd4, 4);
        push_phase(3'd5, 4);
        push_phase(3'd6, 8);
        push_phase(3'd0, 0);
        ack_q.push_back(0);
        ack_q.push_back(3);
        wait_cycles(20);
        ped_req = 1'b1;
        wait_cycles(22);
        ped_req = 1'b0;
        wait_cycles(38);

        // 6: reset in the middle of Y1, then a clean restart into G1.
        do_reset(1'b0, 1'b1);
        push_phase(3'd0, 8);
        push_phase(3'd1, 0);
        wait_cycles(14);
        do_reset(1'b0, 1'b0);
        push_phase(3'd0, 0);
        wait_cycles(30);

        check("phase_q_left", phase_q.size(), 0);
        check("ack_q_left", ack_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
